// File: rtl/shift_arb_if.sv
// Request/result bundle for shift_req_arbiter.
//   req0_*/req1_* : producer side (valid/ready handshake plus operand, shift
//                   amount and fill mode)
//   out_*         : result slot toward the consumer (valid/ready, data, id)
// Modports:
//   master : the producers and consumer (drive requests and out_ready)
//   slave  : the arbiter (drives readies and the result slot)
interface shift_arb_if #(
    parameter int WIDTH = 8
);
    localparam int SHW = $clog2(WIDTH);

    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_data;
    logic [SHW-1:0]   req0_shift;
    logic             req0_mode;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_data;
    logic [SHW-1:0]   req1_shift;
    logic             req1_mode;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_id;

    modport master (
        output req0_valid, req0_data, req0_shift, req0_mode,
        output req1_valid, req1_data, req1_shift, req1_mode,
        output out_ready,
        input  req0_ready, req1_ready,
        input  out_valid, out_data, out_id
    );

    modport slave (
        input  req0_valid, req0_data, req0_shift, req0_mode,
        input  req1_valid, req1_data, req1_shift, req1_mode,
        input  out_ready,
        output req0_ready, req1_ready,
        output out_valid, out_data, out_id
    );
endinterface

// File: rtl/shift_req_arbiter.sv
// shift_req_arbiter: two requesters share one right-shift datapath. A
// round-robin arbiter grants at most one request per cycle whenever the single
// output slot is open (empty, or being drained this cycle). The shifted result
// appears in the slot one cycle after the grant and is held until taken.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   bus        shift_arb_if.slave: req0_*/req1_* handshakes, out_* result slot
//   grant_cnt0 saturating grant count for req0 (SHIFT_ARB_STATS_EN only)
//   grant_cnt1 saturating grant count for req1 (SHIFT_ARB_STATS_EN only)
//
// Build option: define SHIFT_ARB_STATS_EN to add the grant counters (CNT_W
// bits each). Arbitration and datapath are identical either way.
module shift_req_arbiter #(
    parameter int WIDTH = 8
`ifdef SHIFT_ARB_STATS_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    shift_arb_if.slave       bus
`ifdef SHIFT_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1
`endif
);
    localparam int SHW = $clog2(WIDTH);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state_reg, state_next;
    logic             prio_reg, prio_next;   // index preferred when both request
    logic [WIDTH-1:0] data_reg, data_next;
    logic             id_reg, id_next;

    logic             slot_open;
    logic             gnt_any;
    logic             gnt_idx;

    logic [WIDTH-1:0]   sel_data;
    logic [SHW-1:0]     sel_shift;
    logic               sel_mode;
    logic               fill;
    logic [2*WIDTH-1:0] ext;
    logic [WIDTH-1:0]   shifted;

    // Arbitration only looks at the valids, so readies never depend on the
    // operand fields. Gating with rst_n keeps both readies low during reset.
    always_comb begin
        slot_open = rst_n && ((state_reg == EMPTY) || bus.out_ready);
        gnt_any   = slot_open && (bus.req0_valid || bus.req1_valid);
        gnt_idx   = (bus.req0_valid && bus.req1_valid) ? prio_reg : bus.req1_valid;
    end

    assign bus.req0_ready = gnt_any && !gnt_idx;
    assign bus.req1_ready = gnt_any && gnt_idx;

    // Shared datapath: place the fill bits above the operand and shift the
    // double-width word, so vacated positions take the fill value.
    always_comb begin
        sel_data  = gnt_idx ? bus.req1_data  : bus.req0_data;
        sel_shift = gnt_idx ? bus.req1_shift : bus.req0_shift;
        sel_mode  = gnt_idx ? bus.req1_mode  : bus.req0_mode;
        fill      = sel_mode & sel_data[WIDTH-1];
        ext       = {{WIDTH{fill}}, sel_data};
        shifted   = WIDTH'(ext >> sel_shift);
    end

    always_comb begin
        state_next = state_reg;
        data_next  = data_reg;
        id_next    = id_reg;
        prio_next  = prio_reg;

        case (state_reg)
            EMPTY: if (gnt_any) state_next = FULL;
            FULL:  if (bus.out_ready && !gnt_any) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase

        if (gnt_any) begin
            data_next = shifted;
            id_next   = gnt_idx;
            prio_next = !gnt_idx;   // the other requester wins the next tie
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= EMPTY;
            data_reg  <= '0;
            id_reg    <= 1'b0;
            prio_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            data_reg  <= data_next;
            id_reg    <= id_next;
            prio_reg  <= prio_next;
        end
    end

    assign bus.out_valid = (state_reg == FULL);
    assign bus.out_data  = data_reg;
    assign bus.out_id    = id_reg;

`ifdef SHIFT_ARB_STATS_EN
    logic [CNT_W-1:0] cnt0_reg, cnt1_reg;

    // Counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_reg <= '0;
            cnt1_reg <= '0;
        end else begin
            if (bus.req0_ready && cnt0_reg != '1) cnt0_reg <= cnt0_reg + 1'b1;
            if (bus.req1_ready && cnt1_reg != '1) cnt1_reg <= cnt1_reg + 1'b1;
        end
    end

    assign grant_cnt0 = cnt0_reg;
    assign grant_cnt1 = cnt1_reg;
`endif
endmodule
